// File: rtl/mb_scan_addr_gen.sv
// Macroblock raster scan address generator: walks a luma frame MB by MB and emits
// one SB-pixel horizontal run per beat, in row or SBxSB sub-block order inside each MB.
module mb_scan_addr_gen #(
  parameter int WIDTH  = 352,
  parameter int HEIGHT = 288,
  parameter int MB     = 16,
  parameter int SB     = 4,
  parameter int XW     = $clog2(WIDTH),
  parameter int YW     = $clog2(HEIGHT),
  parameter int AW     = $clog2(WIDTH*HEIGHT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [AW-1:0] addr,
  output logic [15:0]   mb_idx,
  output logic          sob,
  output logic          eob,
  output logic          eof,
  output logic          busy,
  output logic          done
);

  localparam int CPB = MB / SB;
  localparam int MBX = WIDTH / MB;
  localparam int MBY = HEIGHT / MB;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int RW  = (MB > 1) ? $clog2(MB) : 1;
  localparam int MXW = (MBX > 1) ? $clog2(MBX) : 1;
  localparam int MYW = (MBY > 1) ? $clog2(MBY) : 1;
  localparam int SBS = $clog2(SB);

  localparam logic [CW-1:0]  C_MAX     = CW'(CPB - 1);
  localparam logic [RW-1:0]  R_MAX     = RW'(MB - 1);
  localparam logic [RW-1:0]  R_SUB     = RW'(SB - 1);
  localparam logic [MXW-1:0] MX_MAX    = MXW'(MBX - 1);
  localparam logic [MYW-1:0] MY_MAX    = MYW'(MBY - 1);
  localparam logic [XW-1:0]  MB_XSTEP  = XW'(MB);
  localparam logic [YW-1:0]  MB_YSTEP  = YW'(MB);
  localparam logic [AW-1:0]  ROW_STEP  = AW'(WIDTH);
  localparam logic [AW-1:0]  SB_BACK   = AW'((SB - 1) * WIDTH);
  localparam logic [AW-1:0]  MB_BACK   = AW'((MB - 1) * WIDTH);
  localparam logic           FIRST_EOB = (CPB == 1) && (MB == 1);
  localparam logic           FIRST_EOF = FIRST_EOB && (MBX == 1) && (MBY == 1);

  if ((WIDTH % MB) != 0 || (HEIGHT % MB) != 0 || (MB % SB) != 0) begin : g_bad_geometry
    $error("mb_scan_addr_gen: WIDTH and HEIGHT must be multiples of MB, MB a multiple of SB");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state, state_n;
  logic           mode_q;
  logic [CW-1:0]  cx, cx_n;
  logic [RW-1:0]  ry, ry_n;
  logic [MXW-1:0] mb_x, mbx_n;
  logic [MYW-1:0] mb_y, mby_n;
  logic [XW-1:0]  mbx0, mbx0_n;
  logic [YW-1:0]  mby0, mby0_n;
  logic [AW-1:0]  row_base, rb_n;
  logic [15:0]    idx_n;
  logic [XW-1:0]  x_n;
  logic [YW-1:0]  y_n;
  logic [AW-1:0]  addr_n;
  logic           sob_n, eob_n, eof_n;
  logic           accept_start, advance, finish;

  // done is still high in the first IDLE cycle, which masks a start arriving with it
  assign accept_start = (state == IDLE) && start && !done;
  assign advance      = (state == RUN) && out_ready;
  assign finish       = advance && eof;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept_start) state_n = RUN;
      RUN:     if (finish)       state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next beat: cx counts SB-wide columns, ry counts pixel rows inside the MB.
  // row_base tracks y*WIDTH by adding constant row deltas only.
  always_comb begin
    cx_n   = cx;
    ry_n   = ry;
    mbx_n  = mb_x;
    mby_n  = mb_y;
    mbx0_n = mbx0;
    mby0_n = mby0;
    rb_n   = row_base;
    idx_n  = mb_idx;
    if (cx == C_MAX && ry == R_MAX) begin
      cx_n  = '0;
      ry_n  = '0;
      idx_n = mb_idx + 16'd1;
      if (mb_x != MX_MAX) begin
        mbx_n  = mb_x + MXW'(1);
        mbx0_n = mbx0 + MB_XSTEP;
        rb_n   = row_base - MB_BACK;
      end else begin
        mbx_n  = '0;
        mbx0_n = '0;
        mby_n  = mb_y + MYW'(1);
        mby0_n = mby0 + MB_YSTEP;
        rb_n   = row_base + ROW_STEP;
      end
    end else if (!mode_q) begin
      if (cx != C_MAX) begin
        cx_n = cx + CW'(1);
      end else begin
        cx_n = '0;
        ry_n = ry + RW'(1);
        rb_n = row_base + ROW_STEP;
      end
    end else begin
      // sub-block order: rows of one SBxSB block first, then step right, then down
      if ((ry & R_SUB) != R_SUB) begin
        ry_n = ry + RW'(1);
        rb_n = row_base + ROW_STEP;
      end else if (cx != C_MAX) begin
        cx_n = cx + CW'(1);
        ry_n = ry - R_SUB;
        rb_n = row_base - SB_BACK;
      end else begin
        cx_n = '0;
        ry_n = ry + RW'(1);
        rb_n = row_base + ROW_STEP;
      end
    end
    x_n    = mbx0_n + (XW'(cx_n) << SBS);
    y_n    = mby0_n + YW'(ry_n);
    addr_n = rb_n + AW'(x_n);
    sob_n  = (cx_n == '0) && (ry_n == '0);
    eob_n  = (cx_n == C_MAX) && (ry_n == R_MAX);
    eof_n  = eob_n && (mbx_n == MX_MAX) && (mby_n == MY_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q    <= 1'b0;
      cx        <= '0;
      ry        <= '0;
      mb_x      <= '0;
      mb_y      <= '0;
      mbx0      <= '0;
      mby0      <= '0;
      row_base  <= '0;
      out_valid <= 1'b0;
      x         <= '0;
      y         <= '0;
      addr      <= '0;
      mb_idx    <= '0;
      sob       <= 1'b0;
      eob       <= 1'b0;
      eof       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= finish;
      if (accept_start) begin
        mode_q    <= mode;
        cx        <= '0;
        ry        <= '0;
        mb_x      <= '0;
        mb_y      <= '0;
        mbx0      <= '0;
        mby0      <= '0;
        row_base  <= '0;
        out_valid <= 1'b1;
        busy      <= 1'b1;
        x         <= '0;
        y         <= '0;
        addr      <= '0;
        mb_idx    <= '0;
        sob       <= 1'b1;
        eob       <= FIRST_EOB;
        eof       <= FIRST_EOF;
      end else if (finish) begin
        out_valid <= 1'b0;
        busy      <= 1'b0;
        x         <= '0;
        y         <= '0;
        addr      <= '0;
        mb_idx    <= '0;
        sob       <= 1'b0;
        eob       <= 1'b0;
        eof       <= 1'b0;
      end else if (advance) begin
        cx       <= cx_n;
        ry       <= ry_n;
        mb_x     <= mbx_n;
        mb_y     <= mby_n;
        mbx0     <= mbx0_n;
        mby0     <= mby0_n;
        row_base <= rb_n;
        x        <= x_n;
        y        <= y_n;
        addr     <= addr_n;
        mb_idx   <= idx_n;
        sob      <= sob_n;
        eob      <= eob_n;
        eof      <= eof_n;
      end
    end
  end

endmodule

// File: tb/tb_mb_scan_addr_gen.sv
// Bench for mb_scan_addr_gen: a 32x32 instance and a default-size instance, each
// compared beat by beat against an index-arithmetic model of the scan order.
module tb_mb_scan_addr_gen;

  localparam int MB  = 16;
  localparam int SB  = 4;
  localparam int SW  = 32;
  localparam int SH  = 32;
  localparam int BW  = 352;
  localparam int BH  = 288;
  localparam int SXW = $clog2(SW);
  localparam int SYW = $clog2(SH);
  localparam int SAW = $clog2(SW*SH);
  localparam int BXW = $clog2(BW);
  localparam int BYW = $clog2(BH);
  localparam int BAW = $clog2(BW*BH);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_drv, start_drv, mode_drv, ready_drv, sel;
  logic s_start, b_start;
  assign s_start = start_drv & ~sel;
  assign b_start = start_drv & sel;

  logic           s_valid, s_sob, s_eob, s_eof, s_busy, s_done;
  logic [SXW-1:0] s_x;
  logic [SYW-1:0] s_y;
  logic [SAW-1:0] s_addr;
  logic [15:0]    s_idx;
  logic           b_valid, b_sob, b_eob, b_eof, b_busy, b_done;
  logic [BXW-1:0] b_x;
  logic [BYW-1:0] b_y;
  logic [BAW-1:0] b_addr;
  logic [15:0]    b_idx;

  mb_scan_addr_gen #(.WIDTH(SW), .HEIGHT(SH), .MB(MB), .SB(SB)) dut_s (
    .clk(clk), .reset(reset_drv), .start(s_start), .mode(mode_drv),
    .out_valid(s_valid), .out_ready(ready_drv), .x(s_x), .y(s_y), .addr(s_addr),
    .mb_idx(s_idx), .sob(s_sob), .eob(s_eob), .eof(s_eof), .busy(s_busy), .done(s_done)
  );

  mb_scan_addr_gen dut_b (
    .clk(clk), .reset(reset_drv), .start(b_start), .mode(mode_drv),
    .out_valid(b_valid), .out_ready(ready_drv), .x(b_x), .y(b_y), .addr(b_addr),
    .mb_idx(b_idx), .sob(b_sob), .eob(b_eob), .eof(b_eof), .busy(b_busy), .done(b_done)
  );

  // packed beat: {pad, mb_idx[16], addr[20], y[12], x[12], sob, eob, eof}
  logic [63:0] s_pk, b_pk, v_pk;
  logic        v_valid, v_busy, v_done;
  always_comb begin
    s_pk    = {1'b0, s_idx, 20'(s_addr), 12'(s_y), 12'(s_x), s_sob, s_eob, s_eof};
    b_pk    = {1'b0, b_idx, 20'(b_addr), 12'(b_y), 12'(b_x), b_sob, b_eob, b_eof};
    v_pk    = sel ? b_pk : s_pk;
    v_valid = sel ? b_valid : s_valid;
    v_busy  = sel ? b_busy : s_busy;
    v_done  = sel ? b_done : s_done;
  end

  int total_n = 0;
  int bad_n   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_n++;
    if (got !== exp) begin
      bad_n++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int px, input int py, input int pa, input int pi,
                                     input bit s, input bit e, input bit f);
    logic [63:0] p;
    p = {1'b0, pi[15:0], pa[19:0], py[11:0], px[11:0], s, e, f};
    return p;
  endfunction

  // Reference order computed directly from the beat index within each macroblock
  task automatic build(input int w, input int h, input bit m);
    int bpm, cpb, c, r, bx, by, px, py, idx;
    bit last;
    exp_q.delete();
    bpm = MB * MB / SB;
    cpb = MB / SB;
    idx = 0;
    for (int my = 0; my < h / MB; my++) begin
      for (int mx = 0; mx < w / MB; mx++) begin
        for (int k = 0; k < bpm; k++) begin
          if (!m) begin
            c  = k % cpb;
            r  = k / cpb;
            px = mx * MB + c * SB;
            py = my * MB + r;
          end else begin
            r  = k % SB;
            bx = (k / SB) % cpb;
            by = k / (SB * cpb);
            px = mx * MB + bx * SB;
            py = my * MB + by * SB + r;
          end
          last = (k == bpm - 1) && (mx == w / MB - 1) && (my == h / MB - 1);
          exp_q.push_back(pk(px, py, py * w + px, idx, k == 0, k == bpm - 1, last));
        end
        idx++;
      end
    end
  endtask

  task automatic run_scan(input bit m, input int pct, input int rst_at, input bit poke);
    int n, total, budget;
    bit stall, fin, rdy;
    logic [63:0] cur, snap;
    if (sel) build(BW, BH, m);
    else     build(SW, SH, m);
    got_q.delete();
    total  = exp_q.size();
    budget = total * 6 + 200;
    n = 0; stall = 0; fin = 0; snap = '0;
    @(negedge clk);
    mode_drv  = m;
    start_drv = 1'b1;
    @(negedge clk);
    start_drv = 1'b0;
    mode_drv  = ~m;
    for (int cyc = 0; cyc < budget && !fin; cyc++) begin
      cur = v_pk;
      if (stall) check("hold", cur, snap);
      stall     = 0;
      start_drv = 1'b0;
      if (n == total) begin
        check("done_pulse", 64'({v_done, v_valid, v_busy}), 64'b100);
        if (poke) start_drv = 1'b1;
        fin = 1;
      end else if (rst_at >= 0 && n == rst_at) begin
        reset_drv = 1'b1;
        @(negedge clk);
        reset_drv = 1'b0;
        check("rst_beat", v_pk, 64'd0);
        check("rst_ctl", 64'({v_valid, v_busy, v_done}), 64'd0);
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("rst_no_done", 64'({v_valid, v_busy, v_done}), 64'd0);
        end
        fin = 1;
      end else begin
        check("run_ctl", 64'({v_valid, v_busy, v_done}), 64'b110);
        rdy       = ($urandom_range(99) < pct);
        ready_drv = rdy;
        if (rdy) begin
          check("beat", cur, exp_q[n]);
          got_q.push_back(cur);
          n++;
        end else begin
          snap  = cur;
          stall = 1;
        end
        if (poke && n == 50) start_drv = 1'b1;
      end
      @(negedge clk);
    end
    if (!fin) check("timeout", 64'(n), 64'(total));
    start_drv = 1'b0;
    check("idle_after", 64'({v_valid, v_busy, v_done}), 64'd0);
  endtask

  initial begin
    reset_drv = 1'b1;
    start_drv = 1'b0;
    mode_drv  = 1'b0;
    ready_drv = 1'b1;
    sel       = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_s", s_pk, 64'd0);
    check("reset_s_ctl", 64'({s_valid, s_busy, s_done}), 64'd0);
    check("reset_b", b_pk, 64'd0);
    check("reset_b_ctl", 64'({b_valid, b_busy, b_done}), 64'd0);
    reset_drv = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_s_ctl", 64'({s_valid, s_busy, s_done}), 64'd0);

    // row raster, always ready
    run_scan(1'b0, 100, -1, 1'b0);
    check("s1_count", 64'(got_q.size()), 64'd256);
    check("s1_b1", got_q[1], pk(4, 0, 4, 0, 0, 0, 0));
    check("s1_b3", got_q[3], pk(12, 0, 12, 0, 0, 0, 0));
    check("s1_b4", got_q[4], pk(0, 1, 32, 0, 0, 0, 0));
    check("s1_b63", got_q[63], pk(12, 15, 492, 0, 0, 1, 0));
    check("s1_b64", got_q[64], pk(16, 0, 16, 1, 1, 0, 0));
    check("s1_b255", got_q[255], pk(28, 31, 1020, 3, 0, 1, 1));

    // sub-block order
    run_scan(1'b1, 100, -1, 1'b0);
    check("s2_b1", got_q[1], pk(0, 1, 32, 0, 0, 0, 0));
    check("s2_b4", got_q[4], pk(4, 0, 4, 0, 0, 0, 0));
    check("s2_b15", got_q[15], pk(12, 3, 108, 0, 0, 0, 0));
    check("s2_b16", got_q[16], pk(0, 4, 128, 0, 0, 0, 0));
    check("s2_b63", got_q[63], pk(12, 15, 492, 0, 0, 1, 0));

    // back-pressure in both orders
    run_scan(1'b0, 50, -1, 1'b0);
    check("s4_count", 64'(got_q.size()), 64'd256);
    run_scan(1'b1, 50, -1, 1'b0);

    // stray starts during the scan and in the done cycle, then a clean restart
    run_scan(1'b0, 100, -1, 1'b1);
    check("s5_count", 64'(got_q.size()), 64'd256);
    run_scan(1'b0, 70, -1, 1'b0);
    check("s5_restart", got_q[0], pk(0, 0, 0, 0, 1, 0, 0));

    // reset in the middle of a scan, then a fresh scan
    run_scan(1'b0, 100, 100, 1'b0);
    check("s6_partial", 64'(got_q.size()), 64'd100);
    run_scan(1'b0, 100, -1, 1'b0);
    check("s6_b0", got_q[0], pk(0, 0, 0, 0, 1, 0, 0));

    // full-size frame
    sel = 1'b1;
    run_scan(1'b0, 100, -1, 1'b0);
    check("s3_count", 64'(got_q.size()), 64'd25344);
    check("s3_last", got_q[25343], pk(348, 287, 101372, 395, 0, 1, 1));

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule

// File: doc/mb_scan_addr_gen.md
Name: mb_scan_addr_gen

Overview:
- Parametrised macroblock scan address generator for the H.264 encoder input path.
- Walks a WIDTH x HEIGHT luma frame in macroblock raster order and emits one beat per SB-pixel horizontal run.
- Each beat carries pixel coordinates, the linear frame address and block-boundary flags, under a valid/ready handshake.
- Two intra-macroblock orders are supported: row raster, or SBxSB sub-block order. It feeds the frame-buffer read port and the MB loader.

Parameters:
- WIDTH, 352, frame width in pixels; multiple of MB.
- HEIGHT, 288, frame height in pixels; multiple of MB.
- MB, 16, macroblock edge in pixels; power of two.
- SB, 4, pixels per beat and sub-block edge; power of two, divides MB.
- XW, $clog2(WIDTH), x coordinate width.
- YW, $clog2(HEIGHT), y coordinate width.
- AW, $clog2(WIDTH*HEIGHT), address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse; begins a frame scan when idle
- mode  in  1  0 = row raster inside MB, 1 = SBxSB sub-block order; sampled on accepted start
- out_valid  out  1  beat valid
- out_ready  in  1  consumer accepts beat
- x  out  XW  pixel column of first pixel of beat
- y  out  YW  pixel row of beat
- addr  out  AW  y*WIDTH + x
- mb_idx  out  16  macroblock index in frame, raster order from 0
- sob  out  1  first beat of a macroblock
- eob  out  1  last beat of a macroblock
- eof  out  1  last beat of the frame
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse after the eof beat is accepted

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, mode register 0.
- FSM states and transitions:
  - IDLE: start=1 latches mode, zeroes all counters, moves to RUN. out_valid rises the following cycle with beat 0.
  - RUN: busy=1 and out_valid=1 continuously.
    - Beat accepted (out_valid & out_ready): outputs advance to the next beat on the next edge.
    - out_ready=0: every output holds stable.
    - eof beat accepted: out_valid drops, done=1 for exactly one cycle, return to IDLE.
- start is ignored in RUN. start in the same cycle that done is pulsed is also ignored; it must arrive once in IDLE.
- Counters: mb_x in 0..WIDTH/MB-1, mb_y in 0..HEIGHT/MB-1; intra-MB counters as below. Beats per MB = MB*MB/SB in both modes.
- Mode 0 (row raster inside MB):
  - c = beat column, 0..MB/SB-1, fastest; r = row, 0..MB-1.
  - x = mb_x*MB + c*SB, y = mb_y*MB + r.
- Mode 1 (sub-block order inside MB):
  - r in 0..SB-1 fastest, then bx in 0..MB/SB-1, then by in 0..MB/SB-1.
  - x = mb_x*MB + bx*SB, y = mb_y*MB + by*SB + r.
- MB wrap: after eob, mb_x increments. At WIDTH/MB-1, mb_x wraps to 0 and mb_y increments. mb_idx increments on every MB boundary.
- Flags: sob is 1 when all intra-MB counters are 0. eob is 1 when all are at max. eof = eob and mb_x, mb_y both at max.
- Arithmetic: addr uses a registered row-base accumulator (row base + x), not a multiplier. No truncation for legal parameters; WIDTH*HEIGHT must fit in AW.
- All outputs registered; no combinational path from out_ready to any output.
- Reset mid-scan: next cycle returns to IDLE with all outputs 0. No done pulse.
- Elaboration: error if WIDTH%MB, HEIGHT%MB or MB%SB is non-zero.

Test Plan:
1. WIDTH=32, HEIGHT=32, mode 0, out_ready=1 -> 256 beats. Beats 0..4 are (x,y) = (0,0), (4,0), (8,0), (12,0), (0,1). Beat 63 = (12,15) with eob=1. Beat 64 = (16,0), addr=16, sob=1, mb_idx=1. Beat 255 = (28,31), addr=1020, eof=1. done pulses on the cycle after beat 255.
2. Same frame, mode 1 -> beats 0..4 are (0,0), (0,1), (0,2), (0,3), (4,0). Beat 15 = (12,3); beat 16 = (0,4). Beat 63 = (12,15) with eob=1.
3. Default parameters, mode 0 -> 25344 beats, 396 MBs. Last beat = (348,287), addr=101372, mb_idx=395, eof=1.
4. Random out_ready (≈50% low) -> outputs bit-stable while valid&!ready. Accepted beat sequence is identical to scenario 1.
5. start pulsed during RUN, and in the done cycle -> ignored. Beat count is unchanged and a fresh start in IDLE restarts at (0,0).
6. reset asserted at beat 100 of scenario 1 -> next cycle out_valid=0, busy=0, no done. A following start produces beat 0 = (0,0), mb_idx=0.
